// File: rtl/sensor_debounce.sv
// sensor_debounce: four-channel sensor front end (gas, smoke, humidity, temperature).
// Each raw line passes through a two-flop synchronizer. A per-channel 8-bit counter
// then debounces it on sample_en strobes, so the committed level only changes after
// DEB_COUNT consecutive disagreeing samples.
// Optional feature: define SENSOR_CHATTER_EN to count aborted transitions per channel
// and raise a sticky fault bit once CHATTER_LIMIT is reached.
module sensor_debounce #(
    parameter int DEB_COUNT     = 4,
    parameter int CHATTER_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       raw_g,
    input  logic       raw_s,
    input  logic       raw_h,
    input  logic       raw_t,
    output logic       IG,
    output logic       IS,
    output logic       IH,
    output logic       IT,
    output logic       settled,
    output logic [3:0] fault,
    input  logic       fault_clr
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_COUNT - 1);
    localparam logic [7:0] DEB_FULL = 8'(DEB_COUNT);

    // Channel order everywhere is {t,h,s,g} = [3:0]
    logic [3:0] raw_vec;
    logic [3:0] sync_p0;
    logic [3:0] sync_p1;
    logic [3:0] level;
    logic [7:0] cnt [4];
    logic [7:0] strobe_cnt;
    logic       cnt_all_zero;

    assign raw_vec = {raw_t, raw_h, raw_s, raw_g};

    // Two-flop synchronizer, runs every cycle independent of the sample strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 4'b0000;
            sync_p1 <= 4'b0000;
        end else begin
            sync_p0 <= raw_vec;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: count consecutive disagreeing samples, commit on the DEB_COUNT-th
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 8'd0;
            end
        end else if (sample_en) begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == level[i]) begin
                    cnt[i] <= 8'd0;
                end else if (cnt[i] == DEB_LAST) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= 8'd0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // Saturating strobe counter so settled cannot assert before one full debounce window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_cnt <= 8'd0;
        end else if (sample_en && (strobe_cnt != DEB_FULL)) begin
            strobe_cnt <= strobe_cnt + 8'd1;
        end
    end

    assign cnt_all_zero = (cnt[0] == 8'd0) && (cnt[1] == 8'd0) &&
                          (cnt[2] == 8'd0) && (cnt[3] == 8'd0);
    assign settled      = (strobe_cnt == DEB_FULL) && cnt_all_zero;

    assign {IT, IH, IS, IG} = level;

`ifdef SENSOR_CHATTER_EN
    localparam logic [3:0] CHAT_LIM = 4'(CHATTER_LIMIT);

    logic [3:0] commit;
    logic [3:0] abort;
    logic [3:0] chat     [4];
    logic [3:0] chat_nxt [4];
    logic [3:0] fault_r;

    // Classify each channel's sample: commit ends a transition, abort kills one mid-way
    always_comb begin
        commit = 4'b0000;
        abort  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            commit[i] = sample_en && (sync_p1[i] != level[i]) && (cnt[i] == DEB_LAST);
            abort[i]  = sample_en && (sync_p1[i] == level[i]) && (cnt[i] != 8'd0);
        end
    end

    // Next chatter count: cleared by a commit, saturating increment on an abort
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            chat_nxt[i] = chat[i];
            if (commit[i]) begin
                chat_nxt[i] = 4'd0;
            end else if (abort[i] && (chat[i] != 4'hF)) begin
                chat_nxt[i] = chat[i] + 4'd1;
            end
        end
    end

    // Chatter counters and sticky fault bits; fault_clr beats a same-cycle set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                chat[i] <= 4'd0;
            end
        end else if (fault_clr) begin
            fault_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                chat[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                chat[i] <= chat_nxt[i];
                if (chat_nxt[i] >= CHAT_LIM) begin
                    fault_r[i] <= 1'b1;
                end
            end
        end
    end

    assign fault = fault_r;
`else
    logic unused_fault_clr;

    assign unused_fault_clr = fault_clr;
    assign fault            = 4'b0000;
`endif

endmodule

// File: tb/tb_sensor_debounce.sv
// tb_sensor_debounce: directed stimulus for sensor_debounce (DEB_COUNT=4, CHATTER_LIMIT=3).
// Stimulus pushes expected output changes and expected snapshots into queues; a monitor
// on the falling edge pops and compares them against the DUT.
module tb_sensor_debounce;

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic       raw_g, raw_s, raw_h, raw_t;
    logic       IG, IS, IH, IT;
    logic       settled;
    logic [3:0] fault;
    logic       fault_clr;

`ifdef SENSOR_CHATTER_EN
    localparam logic [3:0] FAULT_H = 4'b0100;
`else
    localparam logic [3:0] FAULT_H = 4'b0000;
`endif

    typedef struct {
        int         at;
        logic [3:0] outs;
    } chg_t;

    typedef struct {
        string      name;
        int         at;
        logic [8:0] exp;
    } snap_t;

    chg_t  chg_q[$];
    snap_t snap_q[$];

    int tests = 0;
    int fails = 0;
    int edges = 0;

    logic [3:0] mon_prev;
    logic [3:0] mon_cur;
    logic [8:0] mon_got;
    chg_t       mon_c;
    snap_t      mon_s;

    sensor_debounce #(
        .DEB_COUNT    (4),
        .CHATTER_LIMIT(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sample_en(sample_en),
        .raw_g    (raw_g),
        .raw_s    (raw_s),
        .raw_h    (raw_h),
        .raw_t    (raw_t),
        .IG       (IG),
        .IS       (IS),
        .IH       (IH),
        .IT       (IT),
        .settled  (settled),
        .fault    (fault),
        .fault_clr(fault_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edges++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_change(input int at, input logic [3:0] outs);
        chg_t c;
        c.at   = at;
        c.outs = outs;
        chg_q.push_back(c);
    endtask

    task automatic expect_snap(input string name, input int at, input logic s,
                               input logic [3:0] f, input logic [3:0] o);
        snap_t sn;
        sn.name = name;
        sn.at   = at;
        sn.exp  = {s, f, o};
        snap_q.push_back(sn);
    endtask

    // Monitor: output changes are checked against the change queue (value and edge),
    // snapshots {settled, fault, IT,IH,IS,IG} are checked when their edge arrives
    initial begin
        mon_prev = 4'b0000;
        forever begin
            @(negedge clk);
            mon_cur = {IT, IH, IS, IG};
            if (mon_cur !== mon_prev) begin
                tests++;
                if (chg_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change: got outs %b at edge %0d, want no change",
                             mon_cur, edges);
                end else begin
                    mon_c = chg_q.pop_front();
                    if ((mon_c.at != edges) || (mon_c.outs !== mon_cur)) begin
                        fails++;
                        $display("FAIL out_change: got outs %b at edge %0d, want outs %b at edge %0d",
                                 mon_cur, edges, mon_c.outs, mon_c.at);
                    end
                end
                mon_prev = mon_cur;
            end
            while ((snap_q.size() > 0) && (snap_q[0].at <= edges)) begin
                mon_s   = snap_q.pop_front();
                mon_got = {settled, fault, IT, IH, IS, IG};
                tests++;
                if (mon_got !== mon_s.exp) begin
                    fails++;
                    $display("FAIL %s: got {settled,fault,outs}=%b, want %b at edge %0d",
                             mon_s.name, mon_got, mon_s.exp, edges);
                end
            end
        end
    end

    initial begin
        int e;
        rst       = 1'b1;
        sample_en = 1'b0;
        fault_clr = 1'b0;
        raw_g     = 1'b0;
        raw_s     = 1'b0;
        raw_h     = 1'b0;
        raw_t     = 1'b0;

        // Reset state
        tick(2);
        expect_snap("reset_init", edges, 1'b0, 4'b0000, 4'b0000);
        tick(1);
        rst       = 1'b0;
        sample_en = 1'b1;
        tick(6);
        expect_snap("settled_idle", edges, 1'b1, 4'b0000, 4'b0000);

        // Commit timing: raw_t rises, IT must follow on the 6th edge
        e     = edges;
        raw_t = 1'b1;
        expect_change(e + 6, 4'b1000);
        expect_snap("settled_drop", e + 3, 1'b0, 4'b0000, 4'b0000);
        expect_snap("pre_commit", e + 5, 1'b0, 4'b0000, 4'b0000);
        tick(8);
        expect_snap("commit_done", edges, 1'b1, 4'b0000, 4'b1000);

        // Glitch: 3 high samples on raw_g, no commit, counter back to 0
        e     = edges;
        raw_g = 1'b1;
        expect_snap("glitch_mid", e + 5, 1'b0, 4'b0000, 4'b1000);
        tick(3);
        raw_g = 1'b0;
        tick(5);
        expect_snap("glitch_reject", edges, 1'b1, 4'b0000, 4'b1000);

        // Strobe gating: one strobe every 10 clk, IS rises on the 4th
        sample_en = 1'b0;
        raw_s     = 1'b1;
        tick(3);
        for (int k = 1; k <= 4; k++) begin
            tick(9);
            if (k == 4) expect_change(edges + 1, 4'b1010);
            sample_en = 1'b1;
            tick(1);
            sample_en = 1'b0;
            if (k == 2) expect_snap("strobe_hold", edges + 5, 1'b0, 4'b0000, 4'b1000);
        end
        tick(3);
        expect_snap("strobe_commit", edges, 1'b1, 4'b0000, 4'b1010);
        sample_en = 1'b1;

        // Chatter: three aborted 2-sample bursts on raw_h
        for (int b = 0; b < 3; b++) begin
            raw_h = 1'b1;
            tick(2);
            raw_h = 1'b0;
            tick(5);
        end
        expect_snap("chatter_fault", edges, 1'b1, FAULT_H, 4'b1010);
        tick(1);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        expect_snap("fault_cleared", edges, 1'b1, 4'b0000, 4'b1010);
        tick(1);

        // Simultaneous change on g and t
        e     = edges;
        raw_g = 1'b1;
        raw_t = 1'b0;
        expect_change(e + 6, 4'b0011);
        expect_snap("simul_mid", e + 4, 1'b0, 4'b0000, 4'b1010);
        tick(8);
        expect_snap("simul_done", edges, 1'b1, 4'b0000, 4'b0011);

        // Asynchronous reset mid-debounce, then recovery
        raw_h = 1'b1;
        tick(3);
        rst = 1'b1;
        expect_change(edges, 4'b0000);
        expect_snap("reset_async", edges, 1'b0, 4'b0000, 4'b0000);
        tick(2);
        rst = 1'b0;
        e   = edges;
        expect_change(e + 6, 4'b0111);
        expect_snap("post_reset_mid", e + 4, 1'b0, 4'b0000, 4'b0000);
        tick(10);
        expect_snap("post_reset", edges, 1'b1, 4'b0000, 4'b0111);
        tick(3);

        tests++;
        if (chg_q.size() != 0) begin
            fails++;
            $display("FAIL pending_changes: got %0d left, want 0", chg_q.size());
        end
        tests++;
        if (snap_q.size() != 0) begin
            fails++;
            $display("FAIL pending_snaps: got %0d left, want 0", snap_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
